// File: rtl/dut_mul_pipe_rndsat_if.sv
// Operand/result bundle for the rounding, saturating multiplier pipeline.
// The master side drives operands and the clock enable; the slave side returns results.
interface dut_mul_pipe_rndsat_if #(
    parameter int DIN0_WIDTH = 17,
    parameter int DIN1_WIDTH = 15,
    parameter int DOUT_WIDTH = 16
);
    logic                  ce;
    logic                  in_valid;
    logic [DIN0_WIDTH-1:0] din0;
    logic [DIN1_WIDTH-1:0] din1;
    logic                  out_valid;
    logic [DOUT_WIDTH-1:0] dout;
    logic                  sat_flag;

    modport master (
        output ce, in_valid, din0, din1,
        input  out_valid, dout, sat_flag
    );

    modport slave (
        input  ce, in_valid, din0, din1,
        output out_valid, dout, sat_flag
    );
endinterface

// File: rtl/dut_mul_pipe_rndsat.sv
// Pipelined fixed-point multiplier: exact product, arithmetic shift, round-half-up,
// saturate or wrap to DOUT_WIDTH. NUM_STAGE registers in total, frozen while ce=0.
module dut_mul_pipe_rndsat #(
    parameter int DIN0_WIDTH  = 17,
    parameter bit DIN0_SIGNED = 1'b0,
    parameter int DIN1_WIDTH  = 15,
    parameter bit DIN1_SIGNED = 1'b1,
    parameter int DOUT_WIDTH  = 16,
    parameter bit DOUT_SIGNED = 1'b1,
    parameter int SHIFT       = 15,
    parameter bit ROUND       = 1'b1,
    parameter bit SAT         = 1'b1,
    parameter int NUM_STAGE   = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    dut_mul_pipe_rndsat_if.slave bus
);
    localparam int PW  = DIN0_WIDTH + DIN1_WIDTH + 1;
    localparam int XW  = PW + 1;
    localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic signed [XW-1:0] ONE   = XW'(1);
    localparam logic signed [XW-1:0] RND_C = (ROUND && SHIFT > 0) ? (ONE <<< RSH) : '0;
    localparam logic signed [XW-1:0] MAX_C = DOUT_SIGNED ? (ONE <<< (DOUT_WIDTH - 1)) - ONE
                                                         : (ONE <<< DOUT_WIDTH) - ONE;
    localparam logic signed [XW-1:0] MIN_C = DOUT_SIGNED ? -(ONE <<< (DOUT_WIDTH - 1)) : '0;

    typedef struct packed {
        logic [DOUT_WIDTH-1:0] dout;
        logic                  sat;
    } res_t;

    function automatic logic signed [PW-1:0] ext0(input logic [DIN0_WIDTH-1:0] x);
        logic fill;
        fill = DIN0_SIGNED ? x[DIN0_WIDTH-1] : 1'b0;
        return {{(PW - DIN0_WIDTH){fill}}, x};
    endfunction

    function automatic logic signed [PW-1:0] ext1(input logic [DIN1_WIDTH-1:0] x);
        logic fill;
        fill = DIN1_SIGNED ? x[DIN1_WIDTH-1] : 1'b0;
        return {{(PW - DIN1_WIDTH){fill}}, x};
    endfunction

    // The rounding add gets one guard bit so the most positive product cannot overflow.
    function automatic res_t rnd_sat(input logic signed [PW-1:0] p);
        logic signed [XW-1:0] sum;
        logic signed [XW-1:0] r;
        res_t                 o;
        sum   = {p[PW-1], p} + RND_C;
        r     = sum >>> SHIFT;
        o.sat = (r > MAX_C) || (r < MIN_C);
        if (SAT && (r > MAX_C))      o.dout = MAX_C[DOUT_WIDTH-1:0];
        else if (SAT && (r < MIN_C)) o.dout = MIN_C[DOUT_WIDTH-1:0];
        else                         o.dout = r[DOUT_WIDTH-1:0];
        return o;
    endfunction

    logic [NUM_STAGE-1:0] vld_d, vld_q;
    res_t                 res_d, res_q;
    logic signed [PW-1:0] prod_fin;

    if (NUM_STAGE == 1) begin : g_s1
        assign prod_fin = ext0(bus.din0) * ext1(bus.din1);
    end else begin : g_sn
        logic [DIN0_WIDTH-1:0] a_d, a_q;
        logic [DIN1_WIDTH-1:0] b_d, b_q;
        logic signed [PW-1:0]  prod;

        always_comb begin
            a_d = a_q;
            b_d = b_q;
            if (bus.ce) begin
                a_d = bus.din0;
                b_d = bus.din1;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                a_q <= '0;
                b_q <= '0;
            end else begin
                a_q <= a_d;
                b_q <= b_d;
            end
        end

        assign prod = ext0(a_q) * ext1(b_q);

        if (NUM_STAGE == 2) begin : g_s2
            assign prod_fin = prod;
        end else begin : g_s3
            localparam int ND = NUM_STAGE - 2;
            logic [ND-1:0][PW-1:0] pp_d, pp_q;

            // Extra latency is spent delaying the finished product.
            always_comb begin
                pp_d = pp_q;
                if (bus.ce) pp_d = (ND * PW)'({pp_q, prod});
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) pp_q <= '0;
                else       pp_q <= pp_d;
            end

            assign prod_fin = $signed(pp_q[ND-1]);
        end
    end

    always_comb begin
        vld_d = vld_q;
        res_d = res_q;
        if (bus.ce) begin
            vld_d = NUM_STAGE'({vld_q, bus.in_valid});
            res_d = rnd_sat(prod_fin);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            res_q <= '0;
        end else begin
            vld_q <= vld_d;
            res_q <= res_d;
        end
    end

    assign bus.out_valid = vld_q[NUM_STAGE-1];
    assign bus.dout      = res_q.dout;
    assign bus.sat_flag  = res_q.sat;
endmodule
